tx_sched: RTL and testbench

Ping-pong frame scheduler in front of the RGMII transmit datapath. Accepts a byte stream from a producer and packs it into two 1024-byte payload banks. Launches one fixed-length frame per full bank by toggling the transmitter's bank-select/start line, and serves the transmitter's buffer reads. Enforces the inter-frame gap and releases each bank only after its frame has fully left the wire.

---
 rtl/tx_pkg.sv | 24 ++
 rtl/tx_bankram.sv | 34 +++
 rtl/tx_sched.sv | 169 ++++++++++++++++
 tb/tb_tx_sched.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_pkg.sv
// tx_pkg: shared defaults and state encodings for the ping-pong transmit scheduler.
package tx_pkg;

    // Payload bytes per frame (bank size); must be a power of two.
    localparam int PAYLOAD_DEF      = 1024;
    // clk125 cycles the transmitter spends on one frame on the wire.
    localparam int FRAME_CYCLES_DEF = 1052;
    // Extra idle cycles held after every frame.
    localparam int IFG_DEF          = 12;

    // Lifecycle of one payload bank.
    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_state_t;

    // Launcher states.
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } sched_state_t;

endpackage

// File: rtl/tx_bankram.sv
// tx_bankram: two payload banks in one simple dual-port RAM.
// One write port, one registered read port; read and write are independent,
// and a same-address read/write returns the old byte.
module tx_bankram #(
    parameter int AW = 11
) (
    input  logic          clk125,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [0:(1 << AW) - 1];

    // Write port: store the accepted producer byte.
    always_ff @(posedge clk125) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port: one-cycle registered read, cleared to zero by reset.
    always_ff @(posedge clk125 or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= 8'd0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/tx_sched.sv
// tx_sched: packs a producer byte stream into two alternating payload banks,
// launches one fixed-length frame per full bank by toggling idx, holds the
// inter-frame gap, and frees each bank only after its frame has left the wire.
module tx_sched
    import tx_pkg::*;
#(
    parameter int PAYLOAD      = PAYLOAD_DEF,
    parameter int FRAME_CYCLES = FRAME_CYCLES_DEF,
    parameter int IFG          = IFG_DEF
) (
    input  logic                      clk125,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic                      wr_valid,
    input  logic [7:0]                wr_data,
    output logic                      wr_ready,
    input  logic [$clog2(PAYLOAD):0]  rd_addr,
    output logic [7:0]                rd_data,
    output logic                      idx,
    output logic                      busy,
    output logic [15:0]               frames_sent
);

    localparam int AW       = $clog2(PAYLOAD);
    localparam int GAP_LAST = FRAME_CYCLES + IFG - 1;
    localparam int GW       = $clog2(FRAME_CYCLES + IFG);

    localparam logic [AW-1:0] WLAST = AW'(PAYLOAD - 1);
    localparam logic [GW-1:0] GLAST = GW'(GAP_LAST);

    // Write side
    logic            wbank_reg;
    logic [AW-1:0]   waddr_reg;
    logic            wr_accept;

    // Bank lifecycle, one 2-bit bank_state_t code per bank
    logic [1:0][1:0] bank_reg;
    logic [1:0][1:0] bank_next;

    // Launcher
    sched_state_t    state_reg;
    sched_state_t    state_next;
    logic            sbank_reg;
    logic [GW-1:0]   gapcnt_reg;
    logic            idx_reg;
    logic [15:0]     frames_reg;
    logic            launch_s;
    logic            release_s;

    // Ready depends only on registered bank state, never on wr_valid.
    assign wr_ready  = (bank_reg[wbank_reg] != FULL);
    assign wr_accept = wr_valid && wr_ready;

    // Write pointer: advance on every accept, flip banks after the last offset.
    always_ff @(posedge clk125 or negedge rst_n) begin
        if (!rst_n) begin
            wbank_reg <= 1'b0;
            waddr_reg <= '0;
        end else if (wr_accept) begin
            waddr_reg <= waddr_reg + AW'(1);
            if (waddr_reg == WLAST) begin
                wbank_reg <= ~wbank_reg;
            end
        end
    end

    // Per-bank next state. A release outranks a write to the same bank, so
    // the bank is EMPTY the cycle after its frame and gap have finished.
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        assign bank_next[gi] =
            (release_s && (sbank_reg == 1'(gi))) ? EMPTY :
            (wr_accept && (wbank_reg == 1'(gi))) ? ((waddr_reg == WLAST) ? FULL : FILLING) :
            bank_reg[gi];
    end

    // Bank state register.
    always_ff @(posedge clk125 or negedge rst_n) begin
        if (!rst_n) begin
            bank_reg <= {EMPTY, EMPTY};
        end else begin
            bank_reg <= bank_next;
        end
    end

    // Launcher state register.
    always_ff @(posedge clk125 or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Launcher next state: enable is only consulted while idle, so dropping it
    // mid-frame lets the frame and gap run to completion.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (enable && (bank_reg[sbank_reg] == FULL)) begin
                    state_next = SEND;
                end
            end
            SEND: begin
                if (gapcnt_reg == GLAST) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Launcher outputs: launch/release strobes and busy flag.
    always_comb begin
        launch_s  = 1'b0;
        release_s = 1'b0;
        busy      = 1'b0;
        case (state_reg)
            IDLE: begin
                launch_s = enable && (bank_reg[sbank_reg] == FULL);
            end
            SEND: begin
                busy      = 1'b1;
                release_s = (gapcnt_reg == GLAST);
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Launch bookkeeping: idx toggles to the bank being sent, the gap counter
    // times frame+IFG, and the send pointer alternates after each release.
    always_ff @(posedge clk125 or negedge rst_n) begin
        if (!rst_n) begin
            idx_reg    <= 1'b1;
            sbank_reg  <= 1'b0;
            gapcnt_reg <= '0;
            frames_reg <= 16'd0;
        end else begin
            if (launch_s) begin
                idx_reg    <= sbank_reg;
                gapcnt_reg <= '0;
                frames_reg <= frames_reg + 16'd1;
            end else if (state_reg == SEND) begin
                gapcnt_reg <= gapcnt_reg + GW'(1);
            end
            if (release_s) begin
                sbank_reg <= ~sbank_reg;
            end
        end
    end

    assign idx         = idx_reg;
    assign frames_sent = frames_reg;

    tx_bankram #(
        .AW (AW + 1)
    ) u_ram (
        .clk125 (clk125),
        .rst_n  (rst_n),
        .we     (wr_accept),
        .waddr  ({wbank_reg, waddr_reg}),
        .wdata  (wr_data),
        .raddr  (rd_addr),
        .rdata  (rd_data)
    );

endmodule

// File: tb/tb_tx_sched.sv
// tb_tx_sched: directed stimulus with a cycle-stamped scoreboard. Stimulus
// pushes expected levels and expected idx toggles; a negedge monitor pops
// and compares them against the DUT.
module tb_tx_sched;

    logic        clk125 = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        wr_valid;
    logic [7:0]  wr_data;
    logic        wr_ready;
    logic [10:0] rd_addr;
    logic [7:0]  rd_data;
    logic        idx;
    logic        busy;
    logic [15:0] frames_sent;

    tx_sched dut (
        .clk125      (clk125),
        .rst_n       (rst_n),
        .enable      (enable),
        .wr_valid    (wr_valid),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .idx         (idx),
        .busy        (busy),
        .frames_sent (frames_sent)
    );

    always #4 clk125 = ~clk125;

    // Cycle number = count of posedges seen so far.
    int cyc = 0;
    always @(posedge clk125) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    // Level expectation: kind 0 rd_data, 1 wr_ready, 2 busy, 3 frames_sent, 4 idx.
    typedef struct {int cyc; int kind; int val;} exp_t;
    typedef struct {int cyc; int idx; int fs;} lau_t;
    exp_t exp_q[$];
    lau_t lau_q[$];

    function automatic string kname(int k);
        case (k)
            0: return "rd_data";
            1: return "wr_ready";
            2: return "busy";
            3: return "frames_sent";
            default: return "idx";
        endcase
    endfunction

    task automatic chk(string name, int act, int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, req);
        end else begin
            $display("ok   %s cyc=%0d value=%0d", name, cyc, act);
        end
    endtask

    // Monitor: compare due level expectations and every observed idx toggle.
    logic prev_idx = 1'b1;
    always @(negedge clk125) begin
        int   act;
        lau_t e;
        for (int j = exp_q.size() - 1; j >= 0; j--) begin
            if (exp_q[j].cyc == cyc) begin
                case (exp_q[j].kind)
                    0: act = int'(rd_data);
                    1: act = int'(wr_ready);
                    2: act = int'(busy);
                    3: act = int'(frames_sent);
                    default: act = int'(idx);
                endcase
                chk(kname(exp_q[j].kind), act, exp_q[j].val);
                exp_q.delete(j);
            end else if (exp_q[j].cyc < cyc) begin
                checks++;
                failures++;
                $display("FAIL missed_%s due=%0d now=%0d", kname(exp_q[j].kind), exp_q[j].cyc, cyc);
                exp_q.delete(j);
            end
        end
        if (!rst_n) begin
            prev_idx = idx;
        end else if (idx != prev_idx) begin
            prev_idx = idx;
            if (lau_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_launch cyc=%0d idx=%0d frames_sent=%0d required=none", cyc, idx, frames_sent);
            end else begin
                e = lau_q.pop_front();
                chk("launch_cycle", cyc, e.cyc);
                chk("launch_idx", int'(idx), e.idx);
                chk("launch_frames", int'(frames_sent), e.fs);
            end
        end
    end

    task automatic expect_at(int c, int k, int v);
        exp_q.push_back('{c, k, v});
    endtask

    task automatic expect_launch(int c, int i, int fs);
        lau_q.push_back('{c, i, fs});
    endtask

    task automatic tick();
        @(posedge clk125);
        #1;
    endtask

    task automatic wait_until(int c);
        while (cyc < c) tick();
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        wr_valid = 1'b0;
        enable   = 1'b0;
        rd_addr  = 11'd0;
        repeat (3) tick();
        rst_n = 1'b1;
        expect_at(cyc, 0, 0);
        expect_at(cyc, 1, 1);
        expect_at(cyc, 2, 0);
        expect_at(cyc, 3, 0);
        expect_at(cyc, 4, 1);
    endtask

    // Offer n bytes (base+i)%256 back-to-back, honouring wr_ready.
    task automatic wr_bytes(int n, int base);
        int i = 0;
        int budget = 0;
        bit acc;
        while (i < n) begin
            wr_valid = 1'b1;
            wr_data  = 8'((base + i) % 256);
            acc      = wr_ready;
            tick();
            if (acc) i++;
            budget++;
            if (budget > n + 3000) begin
                checks++;
                failures++;
                $display("FAIL wr_timeout accepted=%0d required=%0d", i, n);
                break;
            end
        end
        wr_valid = 1'b0;
    endtask

    task automatic rd(int a, int e);
        rd_addr = 11'(a);
        expect_at(cyc + 1, 0, e);
        tick();
    endtask

    initial begin
        #(8 * 200000);
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w0;
        int l;
        rst_n    = 1'b0;
        enable   = 1'b0;
        wr_valid = 1'b0;
        wr_data  = 8'd0;
        rd_addr  = 11'd0;

        // Single bank fill: launch the cycle after the last accept, then read back.
        do_reset();
        enable = 1'b1;
        w0 = cyc + 1;
        expect_launch(w0 + 1024, 0, 1);
        expect_at(w0 + 1023, 3, 0);
        expect_at(w0 + 1023, 4, 1);
        expect_at(w0 + 1024, 3, 1);
        expect_at(w0 + 1024, 2, 1);
        wr_bytes(1024, 0);
        rd(0, 0);
        rd(1, 1);
        rd(255, 255);
        rd(256, 0);
        rd(1023, 255);
        tick();

        // Continuous 3072 bytes: backpressure until bank 0 is released.
        do_reset();
        enable = 1'b1;
        w0 = cyc + 1;
        expect_launch(w0 + 1024, 0, 1);
        expect_launch(w0 + 2089, 1, 2);
        expect_launch(w0 + 3154, 0, 3);
        expect_at(w0 + 2046, 1, 1);
        expect_at(w0 + 2047, 1, 0);
        expect_at(w0 + 2087, 1, 0);
        expect_at(w0 + 2088, 1, 1);
        wr_bytes(3072, 0);
        wait_until(w0 + 3154 + 300);
        expect_at(cyc, 3, 3);
        tick();

        // enable=0 holds a FULL bank; raising it launches on the next edge.
        do_reset();
        wr_bytes(1024, 0);
        repeat (5000) tick();
        expect_at(cyc, 3, 0);
        expect_at(cyc, 2, 0);
        tick();
        enable = 1'b1;
        l = cyc + 1;
        expect_launch(l, 0, 1);
        tick();
        // Drop enable mid-frame; blocked byte on bank 0 lands at offset 0 after release.
        expect_at(l + 500, 2, 1);
        expect_at(l + 1023, 1, 1);
        expect_at(l + 1024, 1, 0);
        expect_at(l + 1063, 1, 0);
        expect_at(l + 1063, 2, 1);
        expect_at(l + 1064, 1, 1);
        expect_at(l + 1064, 2, 0);
        fork
            begin
                wr_bytes(1024, 128);
                wr_bytes(1, 165);
            end
            begin
                wait_until(l + 500);
                enable = 1'b0;
            end
        join
        wait_until(l + 1065 + 300);
        expect_at(cyc, 3, 1);
        expect_at(cyc, 2, 0);
        tick();
        rd(0, 165);
        rd(1, 1);
        rd(1024, 128);
        rd(2047, 127);
        tick();

        // Asynchronous reset mid-frame with bank 1 half filled.
        do_reset();
        enable = 1'b1;
        w0 = cyc + 1;
        expect_launch(w0 + 1024, 0, 1);
        wr_bytes(1536, 0);
        rd_addr = 11'd5;
        wait_until(w0 + 1699);
        expect_at(cyc, 0, 5);
        expect_at(cyc, 2, 1);
        expect_at(cyc, 3, 1);
        expect_at(cyc, 4, 0);
        tick();
        rst_n = 1'b0;
        expect_at(cyc, 0, 0);
        expect_at(cyc, 1, 1);
        expect_at(cyc, 2, 0);
        expect_at(cyc, 3, 0);
        expect_at(cyc, 4, 1);
        repeat (2) tick();
        rst_n   = 1'b1;
        rd_addr = 11'd0;
        enable  = 1'b1;
        w0 = cyc + 1;
        expect_launch(w0 + 1024, 0, 1);
        wr_bytes(1024, 64);
        rd(0, 64);
        rd(1023, 63);
        repeat (20) tick();

        if (lau_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL pending_launches actual=%0d required=0", lau_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
